fsm_key_driver: RTL and testbench

Unlock-sequence transmitter for the obfuscated detector FSM (`fsm`). After a `start` pulse, it drives the KEY_LEN-bit obfuscation key onto the target's serial input `x`, one bit per target clock edge, MSB first. It then hands the line over to user data through a valid/ready handshake, and counts detection pulses that the target reports on `out`. It sits between the test harness / key store and the protected FSM. It also owns the target's clock enable, so the target never consumes an undefined bit.

---
 rtl/obf_pkg.sv | 14 +
 rtl/sat_counter.sv | 23 ++
 rtl/fsm_key_driver.sv | 103 ++++++++++
 tb/tb_fsm_key_driver.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/obf_pkg.sv
// Shared types and constants for the obfuscated-FSM unlock experiments.
// Holds the driver state encoding and the functional key of the protected detector.
package obf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        KEY  = 2'd1,
        PASS = 2'd2
    } state_t;

    localparam int OBF_KEY_LEN = 5;
    localparam logic [OBF_KEY_LEN-1:0] OBF_KEY = 5'b01110;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// Synchronous clear has priority over increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    localparam logic [CNT_W-1:0] ONE = 1;
    localparam logic [CNT_W-1:0] MAX = '1;

    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (inc && (q != MAX)) begin
            q <= q + ONE;
        end
    end

endmodule

// File: rtl/fsm_key_driver.sv
// Sends the obfuscation key MSB-first to the protected detector FSM, then
// passes user data through a valid/ready handshake and counts detections.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | target held (tgt_en=0), waiting for start
// KEY   | shifting key out, one bit per target edge
// PASS  | key sent; data_in/data_valid drive the target until rst
module fsm_key_driver
    import obf_pkg::*;
#(
    parameter int KEY_LEN = OBF_KEY_LEN,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [KEY_LEN-1:0] key_in,
    input  logic               data_in,
    input  logic               data_valid,
    output logic               data_ready,
    output logic               x_out,
    output logic               tgt_en,
    input  logic               tgt_out,
    output logic               unlocked,
    output logic               busy,
    output logic [CNT_W-1:0]   hit_cnt
);

    localparam int BW = (KEY_LEN > 2) ? $clog2(KEY_LEN) : 1;
    localparam logic [BW-1:0] LAST = BW'(KEY_LEN - 1);
    localparam logic [BW-1:0] BONE = 1;

    state_t             state, state_nxt;
    logic [KEY_LEN-1:0] shreg, shreg_nxt;
    logic [BW-1:0]      bcnt, bcnt_nxt;
    logic               acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            bcnt  <= '0;
            acc_q <= 1'b0;
        end else begin
            state <= state_nxt;
            shreg <= shreg_nxt;
            bcnt  <= bcnt_nxt;
            // tgt_out is only meaningful one edge after the target consumed a user bit
            acc_q <= (state == PASS) && data_valid;
        end
    end

    always_comb begin
        state_nxt  = state;
        shreg_nxt  = shreg;
        bcnt_nxt   = bcnt;
        x_out      = 1'b0;
        tgt_en     = 1'b0;
        data_ready = 1'b0;
        busy       = 1'b0;
        unlocked   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    shreg_nxt = key_in;
                    bcnt_nxt  = '0;
                    state_nxt = KEY;
                end
            end
            KEY: begin
                busy      = 1'b1;
                tgt_en    = 1'b1;
                x_out     = shreg[KEY_LEN-1];
                shreg_nxt = shreg << 1;
                bcnt_nxt  = bcnt + BONE;
                if (bcnt == LAST) begin
                    state_nxt = PASS;
                end
            end
            PASS: begin
                // PASS is terminal: the target cannot be relocked without its own reset
                unlocked   = 1'b1;
                data_ready = 1'b1;
                x_out      = data_in;
                tgt_en     = data_valid;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_hit (
        .clk(clk),
        .clr(rst),
        .inc(acc_q & tgt_out),
        .q  (hit_cnt)
    );

endmodule

// File: tb/tb_fsm_key_driver.sv
// Bench for fsm_key_driver: two instances (CNT_W=8 and CNT_W=2) share stimulus
// and a behavioural model of the protected detector drives tgt_out.
module tb_fsm_key_driver;
    import obf_pkg::*;

    localparam int KL = 5;

    logic          clk = 1'b0;
    logic          rst, start, data_in, data_valid;
    logic          tgt_out = 1'b0;
    logic [KL-1:0] key_in;

    logic          data_ready, x_out, tgt_en, unlocked, busy;
    logic [7:0]    hit_cnt;
    logic          data_ready2, x_out2, tgt_en2, unlocked2, busy2;
    logic [1:0]    hit_cnt2;

    int errors = 0;
    int checks = 0;

    bit acc_bits[$];
    bit key_ok;

    always #5 clk = ~clk;

    fsm_key_driver #(.KEY_LEN(KL), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
        .x_out(x_out), .tgt_en(tgt_en), .tgt_out(tgt_out),
        .unlocked(unlocked), .busy(busy), .hit_cnt(hit_cnt)
    );

    fsm_key_driver #(.KEY_LEN(KL), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in),
        .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready2),
        .x_out(x_out2), .tgt_en(tgt_en2), .tgt_out(tgt_out),
        .unlocked(unlocked2), .busy(busy2), .hit_cnt(hit_cnt2)
    );

    // Protected detector: consumes KL key bits, traps on any wrong bit,
    // otherwise flags every third consecutive accepted 1 and starts over.
    logic [KL-1:0] tkey = OBF_KEY;
    int            t_kcnt = 0;
    logic          t_match = 1'b1;
    int            t_run = 0;

    always @(posedge clk) begin
        if (rst) begin
            t_kcnt  <= 0;
            t_match <= 1'b1;
            t_run   <= 0;
            tgt_out <= 1'b0;
        end else if (tgt_en) begin
            if (t_kcnt < KL) begin
                t_match <= t_match && (x_out == tkey[KL-1-t_kcnt]);
                t_kcnt  <= t_kcnt + 1;
                tgt_out <= 1'b0;
            end else if (!t_match) begin
                tgt_out <= 1'b0;
            end else if (x_out) begin
                if (t_run == 2) begin
                    tgt_out <= 1'b1;
                    t_run   <= 0;
                end else begin
                    tgt_out <= 1'b0;
                    t_run   <= t_run + 1;
                end
            end else begin
                tgt_out <= 1'b0;
                t_run   <= 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Number of non-overlapping runs of three accepted 1s
    function automatic int exp_det();
        int run = 0;
        int det = 0;
        if (!key_ok) return 0;
        foreach (acc_bits[i]) begin
            if (acc_bits[i]) begin
                run++;
                if (run == 3) begin
                    det++;
                    run = 0;
                end
            end else begin
                run = 0;
            end
        end
        return det;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},   32'(busy),       0);
        chk({tag, "_unlk"},   32'(unlocked),   0);
        chk({tag, "_tgten"},  32'(tgt_en),     0);
        chk({tag, "_xout"},   32'(x_out),      0);
        chk({tag, "_ready"},  32'(data_ready), 0);
        chk({tag, "_busy2"},  32'(busy2),      0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        data_valid = 1'b0;
        data_in = 1'b0;
        tick();
        rst = 1'b0;
        acc_bits.delete();
        key_ok = 1'b0;
        #1;
        chk_idle("rst");
        chk("rst_hit",  32'(hit_cnt),  0);
        chk("rst_hit2", 32'(hit_cnt2), 0);
    endtask

    task automatic send_key(input logic [KL-1:0] k, input bit hold_start);
        start = 1'b1;
        key_in = k;
        data_valid = 1'b0;
        #1;
        chk("e0_busy",  32'(busy),   0);
        chk("e0_tgten", 32'(tgt_en), 0);
        tick();
        for (int i = 0; i < KL; i++) begin
            start = hold_start ? 1'b1 : 1'($urandom_range(0, 1));
            key_in = KL'($urandom);
            data_valid = 1'($urandom_range(0, 1));
            data_in = 1'($urandom_range(0, 1));
            #1;
            chk($sformatf("key_x%0d", i),  32'(x_out),  32'(k[KL-1-i]));
            chk($sformatf("key_x2_%0d", i), 32'(x_out2), 32'(k[KL-1-i]));
            chk("key_tgten", 32'(tgt_en),     1);
            chk("key_busy",  32'(busy),       1);
            chk("key_unlk",  32'(unlocked),   0);
            chk("key_ready", 32'(data_ready), 0);
            tick();
        end
        start = 1'b0;
        data_valid = 1'b0;
        key_ok = (k == OBF_KEY);
        #1;
        chk("unl_unlk",  32'(unlocked),   1);
        chk("unl_unlk2", 32'(unlocked2),  1);
        chk("unl_ready", 32'(data_ready), 1);
        chk("unl_busy",  32'(busy),       0);
    endtask

    task automatic send_bit(input logic d, input logic v);
        data_in = d;
        data_valid = v;
        start = 1'($urandom_range(0, 1));
        #1;
        chk("pass_x",     32'(x_out),      32'(d));
        chk("pass_tgten", 32'(tgt_en),     32'(v));
        chk("pass_tgte2", 32'(tgt_en2),    32'(v));
        chk("pass_ready", 32'(data_ready), 1);
        chk("pass_unlk",  32'(unlocked),   1);
        if (v) acc_bits.push_back(d);
        tick();
    endtask

    task automatic check_hits(input string tag);
        int det;
        data_valid = 1'b0;
        start = 1'b0;
        tick();
        det = exp_det();
        chk({tag, "_hit8"}, 32'(hit_cnt),  (det > 255) ? 255 : det);
        chk({tag, "_hit2"}, 32'(hit_cnt2), (det > 3) ? 3 : det);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        key_in = '0;
        data_in = 1'b0;
        data_valid = 1'b0;
        tick();
        do_reset();

        // correct key, start held high, then 1,1,1
        send_key(OBF_KEY, 1'b1);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1);
        check_hits("three_ones");

        // valid toggling 1,0,1,0,1 with data 1
        do_reset();
        send_key(OBF_KEY, 1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'((i % 2) == 0));
        check_hits("toggle");

        // wrong key traps the target
        do_reset();
        send_key(5'b11111, 1'b0);
        for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b1);
        check_hits("wrong_key");
        chk("wrong_unlk", 32'(unlocked), 1);

        // reset during the third key bit
        do_reset();
        start = 1'b1;
        key_in = OBF_KEY;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("mid_x2", 32'(x_out), 32'(tkey[KL-3]));
        tick();
        rst = 1'b0;
        acc_bits.delete();
        #1;
        chk_idle("mid_rst");
        tick();
        chk("mid_stay_busy", 32'(busy), 0);
        send_key(OBF_KEY, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1);
        check_hits("after_mid");

        // rst and start together: rst wins
        rst = 1'b1;
        start = 1'b1;
        key_in = OBF_KEY;
        tick();
        rst = 1'b0;
        start = 1'b0;
        acc_bits.delete();
        key_ok = 1'b0;
        #1;
        chk_idle("rst_start");

        // saturation: 12 detections, then 3 more
        do_reset();
        send_key(OBF_KEY, 1'b0);
        for (int i = 0; i < 36; i++) send_bit(1'b1, 1'b1);
        check_hits("sat12");
        for (int i = 0; i < 9; i++) send_bit(1'b1, 1'b1);
        check_hits("sat15");

        // random data and valid after the correct key
        do_reset();
        send_key(OBF_KEY, 1'b0);
        for (int i = 0; i < 80; i++) begin
            send_bit(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
        end
        check_hits("rand_ok");

        // random key (usually wrong) with random data
        do_reset();
        send_key(KL'($urandom), 1'b0);
        for (int i = 0; i < 40; i++) begin
            send_bit(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        check_hits("rand_key");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
